// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register-bank responder.
// Holds the response encoding, the ID word, the FSM state encodings and a byte-lane merge helper.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    localparam logic [31:0] REGFILE_ID = 32'h4158_4C01;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Lanes with a clear strobe bit keep their old contents.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle between a master and the register-bank responder.
// Every channel: a transfer happens on the rising edge where VALID and READY are both high;
// VALID and its payload hold steady until then, and READY may change freely while VALID is low.
interface axi4_lite_regfile_slave_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDRESS-1:0]      S_AWADDR;
    logic                    S_AWVALID;
    logic                    S_AWREADY;
    logic [DATA_WIDTH-1:0]   S_WDATA;
    logic [DATA_WIDTH/8-1:0] S_WSTRB;
    logic                    S_WVALID;
    logic                    S_WREADY;
    logic [1:0]              S_BRESP;
    logic                    S_BVALID;
    logic                    S_BREADY;
    logic [ADDRESS-1:0]      S_ARADDR;
    logic                    S_ARVALID;
    logic                    S_ARREADY;
    logic [DATA_WIDTH-1:0]   S_RDATA;
    logic [1:0]              S_RRESP;
    logic                    S_RVALID;
    logic                    S_RREADY;

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
               S_RDATA, S_RRESP, S_RVALID
    );

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
               S_RDATA, S_RRESP, S_RVALID
    );

endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decode shared by the write and read paths.
// Out-of-range beats misalignment; in-range aligned addresses yield a word index.
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS  = 32,
    parameter int NUM_REGS = 16
) (
    input  logic [ADDRESS-1:0]          addr,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output axi_resp_t                   resp
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDRESS-1:0] LIMIT = ADDRESS'(NUM_REGS * 4);

    always_comb begin
        idx = addr[2 +: IDX_W];
        if (addr >= LIMIT) begin
            resp = DECERR;
        end else if (addr[1:0] != 2'b00) begin
            resp = SLVERR;
        end else begin
            resp = OKAY;
        end
    end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite responder with a built-in register bank; register 0 is a read-only ID word.
// AW and W are captured independently, committed together, and answered on B; reads answer on R.
module axi4_lite_regfile_slave
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    axi4_lite_regfile_slave_if.slave   s,
    output logic [1:0]                 w_state_dbg,
    output logic                       r_state_dbg
);
    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] ST_W_IDLE   = W_IDLE;
    localparam logic [1:0] ST_W_COMMIT = W_COMMIT;
    localparam logic [1:0] ST_W_RESP   = W_RESP;
    localparam logic       ST_R_IDLE   = R_IDLE;
    localparam logic       ST_R_DATA   = R_DATA;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [1:0]              w_state;
    logic                    aw_full;
    logic                    w_full;
    logic [ADDRESS-1:0]      awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;
    logic                    bvalid_q;
    axi_resp_t               bresp_q;

    logic                    r_state;
    logic                    rvalid_q;
    axi_resp_t               rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    aw_ready;
    logic                    w_ready;
    logic                    ar_ready;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;

    logic [IDX_W-1:0]        aw_idx;
    axi_resp_t               aw_dec_resp;
    axi_resp_t               w_resp;
    logic [IDX_W-1:0]        ar_idx;
    axi_resp_t               ar_resp;
    logic [DATA_WIDTH-1:0]   rd_word;

    // READYs are forced low in reset so nothing is accepted before the flags are known clear.
    assign aw_ready = ARESETN && !aw_full && !bvalid_q;
    assign w_ready  = ARESETN && !w_full  && !bvalid_q;
    assign ar_ready = ARESETN && !rvalid_q;

    assign aw_hs = s.S_AWVALID && aw_ready;
    assign w_hs  = s.S_WVALID  && w_ready;
    assign ar_hs = s.S_ARVALID && ar_ready;

    assign s.S_AWREADY = aw_ready;
    assign s.S_WREADY  = w_ready;
    assign s.S_BVALID  = bvalid_q;
    assign s.S_BRESP   = bresp_q;
    assign s.S_ARREADY = ar_ready;
    assign s.S_RVALID  = rvalid_q;
    assign s.S_RRESP   = rresp_q;
    assign s.S_RDATA   = rdata_q;

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    axi4_lite_addr_decode #(
        .ADDRESS  (ADDRESS),
        .NUM_REGS (NUM_REGS)
    ) u_aw_decode (
        .addr (awaddr_q),
        .idx  (aw_idx),
        .resp (aw_dec_resp)
    );

    axi4_lite_addr_decode #(
        .ADDRESS  (ADDRESS),
        .NUM_REGS (NUM_REGS)
    ) u_ar_decode (
        .addr (s.S_ARADDR),
        .idx  (ar_idx),
        .resp (ar_resp)
    );

    // The ID word at index 0 decodes fine but refuses writes.
    always_comb begin
        w_resp = aw_dec_resp;
        if (aw_dec_resp == OKAY && aw_idx == '0) begin
            w_resp = SLVERR;
        end
    end

    always_comb begin
        rd_word = '0;
        if (ar_resp == OKAY) begin
            rd_word = (ar_idx == '0) ? REGFILE_ID : regs[ar_idx];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state  <= ST_W_IDLE;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (w_state)
                ST_W_IDLE: begin
                    if (aw_hs) begin
                        aw_full  <= 1'b1;
                        awaddr_q <= s.S_AWADDR;
                    end
                    if (w_hs) begin
                        w_full  <= 1'b1;
                        wdata_q <= s.S_WDATA;
                        wstrb_q <= s.S_WSTRB;
                    end
                    if ((aw_full || aw_hs) && (w_full || w_hs)) begin
                        w_state <= ST_W_COMMIT;
                    end
                end
                ST_W_COMMIT: begin
                    if (w_resp == OKAY) begin
                        regs[aw_idx] <= merge_lanes(regs[aw_idx], wdata_q, wstrb_q);
                    end
                    aw_full  <= 1'b0;
                    w_full   <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= w_resp;
                    w_state  <= ST_W_RESP;
                end
                ST_W_RESP: begin
                    if (s.S_BREADY) begin
                        bvalid_q <= 1'b0;
                        w_state  <= ST_W_IDLE;
                    end
                end
                default: w_state <= ST_W_IDLE;
            endcase
        end
    end

    // A read on the commit edge samples regs before the nonblocking update lands.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state  <= ST_R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                ST_R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= ar_resp;
                        rdata_q  <= rd_word;
                        r_state  <= ST_R_DATA;
                    end
                end
                ST_R_DATA: begin
                    if (s.S_RREADY) begin
                        rvalid_q <= 1'b0;
                        r_state  <= ST_R_IDLE;
                    end
                end
                default: r_state <= ST_R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave: drivers issue AXI transfers and queue the expected
// responses; a monitor pops and compares whenever a B or R beat is accepted.
module tb_axi4_lite_regfile_slave;
  import axi4_lite_pkg::*;

  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] w_dbg;
  logic r_dbg;

  int errors = 0;
  int checks = 0;
  int b_seen = 0;

  logic [1:0] b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic [1:0] b_e;
  logic [33:0] r_e;

  // clock / reset
  always #5 clk = ~clk;

  axi4_lite_regfile_slave_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_regfile_slave #(
    .DATA_WIDTH(32),
    .ADDRESS(32),
    .NUM_REGS(16)
  ) dut (
    .ACLK(clk),
    .ARESETN(rstn),
    .s(bus),
    .w_state_dbg(w_dbg),
    .r_state_dbg(r_dbg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles, required a handshake", name, TMO);
  endtask

  // scoreboard monitor: a beat is accepted at the next rising edge
  always @(negedge clk) begin
    if (rstn && bus.S_BVALID && bus.S_BREADY) begin
      b_seen++;
      if (b_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bresp_unexpected: got resp %0d, required no response", bus.S_BRESP);
      end else begin
        b_e = b_exp_q.pop_front();
        chk("bresp", 64'(bus.S_BRESP), 64'(b_e));
      end
    end
    if (rstn && bus.S_RVALID && bus.S_RREADY) begin
      if (r_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected: got %0h, required no response", bus.S_RDATA);
      end else begin
        r_e = r_exp_q.pop_front();
        chk("rdata", 64'(bus.S_RDATA), 64'(r_e[31:0]));
        chk("rresp", 64'(bus.S_RRESP), 64'(r_e[33:32]));
      end
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic aw_send(input logic [31:0] a);
    int n = 0;
    bus.S_AWADDR = a;
    bus.S_AWVALID = 1'b1;
    while (!bus.S_AWREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("aw_handshake");
    @(posedge clk); #1;
    bus.S_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb);
    int n = 0;
    bus.S_WDATA = d;
    bus.S_WSTRB = strb;
    bus.S_WVALID = 1'b1;
    while (!bus.S_WREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("w_handshake");
    @(posedge clk); #1;
    bus.S_WVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a);
    int n = 0;
    bus.S_ARADDR = a;
    bus.S_ARVALID = 1'b1;
    while (!bus.S_ARREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("ar_handshake");
    @(posedge clk); #1;
    bus.S_ARVALID = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (b_exp_q.size() != 0 && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("b_response");
  endtask

  task automatic wait_r();
    int n = 0;
    while (r_exp_q.size() != 0 && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("r_response");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                    input logic [1:0] resp, input bit wait_it);
    b_exp_q.push_back(resp);
    fork
      aw_send(a);
      w_send(d, strb);
    join
    if (wait_it) wait_b();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                    input bit wait_it);
    r_exp_q.push_back({resp, d});
    ar_send(a);
    if (wait_it) wait_r();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, 64'(bus.S_AWREADY), 64'd0);
    chk({tag, "_wready"},  64'(bus.S_WREADY),  64'd0);
    chk({tag, "_arready"}, 64'(bus.S_ARREADY), 64'd0);
    chk({tag, "_bvalid"},  64'(bus.S_BVALID),  64'd0);
    chk({tag, "_rvalid"},  64'(bus.S_RVALID),  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_before;
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WVALID = 1'b0;
    bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0;
    bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_rdata", 64'(bus.S_RDATA), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", 64'(bus.S_AWREADY), 64'd1);
    chk("post_reset_wready",  64'(bus.S_WREADY),  64'd1);
    chk("post_reset_arready", 64'(bus.S_ARREADY), 64'd1);
    @(posedge clk); #1;

    // basic write then read
    wr(32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 1);
    rd(32'h04, 32'hDEAD_BEEF, 2'b00, 1);

    // W leads AW by three cycles; partial strobes over a zero register
    b_before = b_seen;
    b_exp_q.push_back(2'b00);
    fork
      w_send(32'h1122_3344, 4'b0101);
      begin
        repeat (3) begin @(posedge clk); #1; end
        aw_send(32'h08);
      end
    join
    wait_b();
    repeat (3) begin @(posedge clk); #1; end
    chk("split_write_b_count", 64'(b_seen - b_before), 64'd1);
    rd(32'h08, 32'h0022_0044, 2'b00, 1);

    // ID register, misaligned and out-of-range accesses, empty strobe
    wr(32'h00, 32'hFFFF_FFFF, 4'hF, 2'b10, 1);
    rd(32'h00, 32'h4158_4C01, 2'b00, 1);
    wr(32'h06, 32'h1234_5678, 4'hF, 2'b10, 1);
    rd(32'h06, 32'h0, 2'b10, 1);
    rd(32'h40, 32'h0, 2'b11, 1);
    wr(32'h40, 32'h1234_5678, 4'hF, 2'b11, 1);
    wr(32'h04, 32'h0BAD_F00D, 4'h0, 2'b00, 1);
    rd(32'h04, 32'hDEAD_BEEF, 2'b00, 1);

    // back-pressure on B and R
    bus.S_BREADY = 1'b0;
    bus.S_RREADY = 1'b0;
    fork
      wr(32'h10, 32'hA5A5_A5A5, 4'hF, 2'b00, 0);
      rd(32'h04, 32'hDEAD_BEEF, 2'b00, 0);
    join
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_bvalid",  64'(bus.S_BVALID),  64'd1);
      chk("stall_bresp",   64'(bus.S_BRESP),   64'd0);
      chk("stall_rvalid",  64'(bus.S_RVALID),  64'd1);
      chk("stall_rdata",   64'(bus.S_RDATA),   64'hDEAD_BEEF);
      chk("stall_awready", 64'(bus.S_AWREADY), 64'd0);
      chk("stall_wready",  64'(bus.S_WREADY),  64'd0);
      chk("stall_arready", 64'(bus.S_ARREADY), 64'd0);
    end
    chk("stall_w_state", 64'(w_dbg), 64'(W_RESP));
    chk("stall_r_state", 64'(r_dbg), 64'(R_DATA));
    @(posedge clk); #1;
    bus.S_BREADY = 1'b1;
    bus.S_RREADY = 1'b1;
    wait_b();
    wait_r();
    rd(32'h10, 32'hA5A5_A5A5, 2'b00, 1);

    // read racing a write to the same register
    wr(32'h0C, 32'd5, 4'hF, 2'b00, 1);
    fork
      wr(32'h0C, 32'd9, 4'hF, 2'b00, 1);
      rd(32'h0C, 32'd5, 2'b00, 1);
    join
    rd(32'h0C, 32'd9, 2'b00, 1);
    fork
      wr(32'h0C, 32'h77, 4'hF, 2'b00, 1);
      begin
        @(posedge clk); #1;
        rd(32'h0C, 32'd9, 2'b00, 1);
      end
    join
    rd(32'h0C, 32'h77, 2'b00, 1);

    // reset while both responses are pending
    bus.S_BREADY = 1'b0;
    bus.S_RREADY = 1'b0;
    fork
      wr(32'h14, 32'h5555_AAAA, 4'hF, 2'b00, 0);
      rd(32'h04, 32'hDEAD_BEEF, 2'b00, 0);
    join
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_bvalid", 64'(bus.S_BVALID), 64'd1);
    chk("pre_reset_rvalid", 64'(bus.S_RVALID), 64'd1);
    rstn = 1'b0;
    b_exp_q.delete();
    r_exp_q.delete();
    @(posedge clk); #1;
    chk_idle_outputs("mid_reset");
    chk("mid_reset_bresp", 64'(bus.S_BRESP), 64'd0);
    rstn = 1'b1;
    bus.S_BREADY = 1'b1;
    bus.S_RREADY = 1'b1;
    @(negedge clk);
    chk("release_awready", 64'(bus.S_AWREADY), 64'd1);
    chk("release_wready",  64'(bus.S_WREADY),  64'd1);
    chk("release_arready", 64'(bus.S_ARREADY), 64'd1);
    @(posedge clk); #1;
    rd(32'h04, 32'h0, 2'b00, 1);
    rd(32'h14, 32'h0, 2'b00, 1);

    repeat (3) begin @(posedge clk); #1; end
    chk("final_b_queue_empty", 64'(b_exp_q.size()), 64'd0);
    chk("final_r_queue_empty", 64'(r_exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
